// File: rtl/bias_add_stage_if.sv
// Row stream carrying one wide row per valid/ready handshake.
// last marks the final row of an instruction.
interface bias_add_stage_if #(
  parameter int W = 512
);
  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/bias_add_stage.sv
// Fetches one bias row from the bias buffer, then adds it lane-wise to each input row and streams the result.
// Define BIAS_ADD_RELU_EN to clamp every negative lane sum to zero in the same cycle.
//
// state  | meaning
// IDLE   | wait for ap_start, latch buffer addr and row_count
// FETCH  | one-cycle read enable on the bias buffer
// WAIT   | capture the returned bias row
// STREAM | accept input rows, load biased rows into the output register
// DRAIN  | last row accepted, hold it until the consumer takes it
// DONE   | one-cycle ap_done
module bias_add_stage #(
  parameter int BIAS_INST_LENGTH   = 128,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_BUF_ADDR_WIDTH   = 9
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [BIAS_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          bias_read_buffer_en,
  output logic [C_BUF_ADDR_WIDTH-1:0]   bias_read_buffer_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] bias_read_buffer_data,
  bias_add_stage_if.slave               in_row,
  bias_add_stage_if.master              out_row
);

  localparam int LANES = C_M_AXI_DATA_WIDTH / C_ADDER_BIT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [C_BUF_ADDR_WIDTH-1:0]     addr_q;
  logic [15:0]                     count_q;
  logic [15:0]                     seen_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   bias_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   data_q;
  logic                            valid_q;
  logic                            last_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   biased;
  logic [C_ADDER_BIT_WIDTH-1:0]    lane_sum;
  logic                            in_ready;
  logic                            accept;
  logic                            last_row;
  logic [15:0]                     inst_count;

  assign inst_count = ctrl_instruction[63:48];
  // count_q is at most 0xFFFF, so seen_q never needs to exceed 0xFFFE here
  assign last_row   = (seen_q == count_q - 16'd1);
  assign accept     = in_ready && in_row.valid;

  logic unused_bits;
  assign unused_bits = ^{ctrl_instruction[BIAS_INST_LENGTH-1:64],
                         ctrl_instruction[47:32+C_BUF_ADDR_WIDTH],
                         ctrl_instruction[31:0], in_row.last};

  always_comb begin
    biased   = '0;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = bias_q[k*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH]
               + in_row.data[k*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
`ifdef BIAS_ADD_RELU_EN
      if (lane_sum[C_ADDER_BIT_WIDTH-1]) lane_sum = '0;
`else
`endif
      biased[k*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] = lane_sum;
    end
  end

  always_comb begin
    state_d             = state_q;
    ap_done             = 1'b0;
    bias_read_buffer_en = 1'b0;
    in_ready            = 1'b0;
    case (state_q)
      S_IDLE:   if (ap_start) state_d = (inst_count == 16'd0) ? S_DONE : S_FETCH;
      S_FETCH: begin
        bias_read_buffer_en = 1'b1;
        state_d             = S_WAIT;
      end
      S_WAIT:   state_d = S_STREAM;
      S_STREAM: begin
        in_ready = !valid_q || out_row.ready;
        if (in_ready && in_row.valid && last_row) state_d = S_DRAIN;
      end
      S_DRAIN:  if (out_row.ready) state_d = S_DONE;
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      seen_q  <= '0;
      bias_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && ap_start) begin
        addr_q  <= ctrl_instruction[32 +: C_BUF_ADDR_WIDTH];
        count_q <= inst_count;
        seen_q  <= '0;
      end
      if (state_q == S_WAIT) bias_q <= bias_read_buffer_data;
      if (accept) begin
        data_q  <= biased;
        valid_q <= 1'b1;
        last_q  <= last_row;
        seen_q  <= seen_q + 16'd1;
      end else if (valid_q && out_row.ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bias_read_buffer_addr = addr_q;
  assign in_row.ready          = in_ready;
  assign out_row.valid         = valid_q;
  assign out_row.data          = data_q;
  assign out_row.last          = last_q;

endmodule

// File: tb/tb_bias_add_stage.sv
// Randomised and directed bench for bias_add_stage; expected rows come from a lane-arithmetic model
// fed by a bench-side bias buffer. Honours BIAS_ADD_RELU_EN the same way the design does.
module tb_bias_add_stage;
  localparam int W  = 512;
  localparam int NL = 16;

  logic         kernel_clk = 1'b0;
  logic         kernel_rst = 1'b1;
  logic         ap_start   = 1'b0;
  logic         ap_done;
  logic [127:0] ctrl_instruction = '0;
  logic         rd_en;
  logic [8:0]   rd_addr;
  logic [W-1:0] rd_data = '0;

  bias_add_stage_if #(.W(W)) in_row ();
  bias_add_stage_if #(.W(W)) out_row ();

  bias_add_stage dut (
    .kernel_clk            (kernel_clk),
    .kernel_rst            (kernel_rst),
    .ap_start              (ap_start),
    .ap_done               (ap_done),
    .ctrl_instruction      (ctrl_instruction),
    .bias_read_buffer_en   (rd_en),
    .bias_read_buffer_addr (rd_addr),
    .bias_read_buffer_data (rd_data),
    .in_row                (in_row),
    .out_row               (out_row)
  );

  always #5 kernel_clk = ~kernel_clk;

  logic [W-1:0] mem [512];

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Read data is only meaningful the cycle after en; otherwise the buffer returns garbage.
  always @(posedge kernel_clk) rd_data <= rd_en ? mem[rd_addr] : rand_row();

  int vectors = 0, miscompares = 0;
  int cyc = 0, accepted, emitted, done_seen, done_cyc, last_out_cyc, start_cyc;
  int en_cnt, ready_hi, cur_count;
  logic [8:0]   en_addr;
  logic [W-1:0] cur_bias, stall_data;
  logic         stall_last;
  bit           stall_prev = 0, lat_pend = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] dir_rows[$];

  function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] d);
    logic [W-1:0] r;
    longint s;
    for (int k = 0; k < NL; k++) begin
      s = (longint'(b[k*32 +: 32]) + longint'(d[k*32 +: 32])) % 64'h1_0000_0000;
`ifdef BIAS_ADD_RELU_EN
      if (s >= 64'h8000_0000) s = 0;
`endif
      r[k*32 +: 32] = s[31:0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle, sample everything for the coming edge, then advance one clock.
  task automatic cycle();
    logic [W-1:0] e;
    #1;
    if (lat_pend) check("lat_valid", out_row.valid, 1'b1);
    if (stall_prev) begin
      check("stall_valid", out_row.valid, 1'b1);
      check("stall_data", out_row.data, stall_data);
      check("stall_last", out_row.last, stall_last);
    end
    stall_prev = (out_row.valid === 1'b1) && (out_row.ready === 1'b0);
    stall_data = out_row.data;
    stall_last = out_row.last;
    lat_pend   = (in_row.valid === 1'b1) && (in_row.ready === 1'b1);
    if (rd_en === 1'b1) begin en_cnt++; en_addr = rd_addr; end
    if (in_row.ready === 1'b1) ready_hi++;
    if (lat_pend) begin
      accepted++;
      exp_q.push_back(model(cur_bias, in_row.data));
    end
    if (out_row.valid === 1'b1 && out_row.ready === 1'b1) begin
      emitted++;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) check("spurious_row", emitted, 0);
      else begin
        e = exp_q.pop_front();
        got_q.push_back(out_row.data);
        check("out_data", out_row.data, e);
        check("out_last", out_row.last, emitted == cur_count);
      end
    end
    if (ap_done === 1'b1) begin done_seen++; done_cyc = cyc; end
    @(posedge kernel_clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [8:0] addr, input int count);
    logic [127:0] inst;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[40:32] = addr;
    inst[63:48] = count[15:0];
    cur_bias = mem[addr]; cur_count = count;
    accepted = 0; emitted = 0; done_seen = 0; en_cnt = 0; en_addr = '0; ready_hi = 0;
    got_q.delete(); exp_q.delete();
    ctrl_instruction = inst;
    ap_start = 1'b1; in_row.valid = 1'b0; out_row.ready = 1'b1;
    start_cyc = cyc;
    cycle();
    ap_start = 1'b0;
    ctrl_instruction = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // rmode: 0 random ready, 1 always ready, 2 toggling; vmode: 1 = in_valid always high
  task automatic run_inst(input logic [8:0] addr, input int count, input int rmode,
                          input int vmode, input int restart_at);
    start(addr, count);
    for (int i = 0; i < count * 12 + 40 && done_seen == 0; i++) begin
      in_row.valid  = (vmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      in_row.data   = (dir_rows.size() > accepted) ? dir_rows[accepted] : rand_row();
      out_row.ready = (rmode == 0) ? 1'($urandom_range(0, 1)) : (rmode == 1) ? 1'b1 : 1'(i % 2 == 0);
      ap_start      = (i == restart_at);
      cycle();
    end
    ap_start = 1'b0; in_row.valid = 1'b1; out_row.ready = 1'b1;
    repeat (4) cycle();
    check("done_count", done_seen, 1);
    check("rows_in", accepted, count);
    check("rows_out", emitted, count);
    check("pending", exp_q.size(), 0);
    check("done_timing", done_cyc, (count == 0) ? start_cyc + 1 : last_out_cyc + 1);
    check("buf_reads", en_cnt, (count == 0) ? 0 : 1);
    if (count > 0) check("buf_addr", en_addr, addr);
    else check("ready_never", ready_hi, 0);
    in_row.valid = 1'b0;
    dir_rows.delete();
  endtask

  task automatic abort_after(input logic [8:0] addr, input int count, input int rows);
    start(addr, count);
    in_row.valid = 1'b1;
    for (int i = 0; i < rows * 4 + 20 && accepted < rows; i++) begin
      in_row.data = rand_row();
      cycle();
    end
    check("abort_rows", accepted, rows);
    kernel_rst = 1'b1;
    cycle();
    kernel_rst = 1'b0;
    lat_pend = 0; stall_prev = 0; exp_q.delete();
    check("rst_out_valid", out_row.valid, 1'b0);
    check("rst_in_ready", in_row.ready, 1'b0);
    check("rst_out_last", out_row.last, 1'b0);
    check("rst_out_data", out_row.data, '0);
    check("rst_done", ap_done, 1'b0);
    check("rst_addr", rd_addr, 9'd0);
    accepted = 0; done_seen = 0; emitted = 0;
    repeat (10) cycle();
    check("abort_no_done", done_seen, 0);
    check("abort_no_rows", accepted + emitted, 0);
    in_row.valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r;
    for (int i = 0; i < 512; i++) mem[i] = rand_row();
    in_row.valid = 1'b1; in_row.data = '0; in_row.last = 1'b0; out_row.ready = 1'b1;
    cur_bias = '0; cur_count = 0;
    repeat (2) cycle();
    kernel_rst = 1'b0;
    check("reset_done", ap_done, 1'b0);
    check("reset_en", rd_en, 1'b0);
    check("reset_in_ready", in_row.ready, 1'b0);
    check("reset_out_valid", out_row.valid, 1'b0);
    check("reset_out_last", out_row.last, 1'b0);
    check("reset_addr", rd_addr, 9'd0);
    check("reset_out_data", out_row.data, '0);
    in_row.valid = 1'b0;
    repeat (2) cycle();

    // 1: bias all ones, rows of 10/20/30
    mem[9'h012] = {NL{32'd1}};
    dir_rows.push_back({NL{32'd10}});
    dir_rows.push_back({NL{32'd20}});
    dir_rows.push_back({NL{32'd30}});
    run_inst(9'h012, 3, 1, 1, -1);
    r = got_q[0]; check("t1_row1", r[31:0], 32'd11);
    r = got_q[1]; check("t1_row2", r[511:480], 32'd21);
    r = got_q[2]; check("t1_row3", r[255:224], 32'd31);

    // 2: wrap, negative sums and lane isolation
    r = '0;
    r[31:0] = 32'h7FFF_FFFF; r[63:32] = 32'hFFFF_FFFB; r[95:64] = 32'hFFFF_FFFF;
    mem[9'h0A5] = r;
    r = '0;
    r[31:0] = 32'd1; r[63:32] = 32'd3; r[95:64] = 32'd1;
    dir_rows.push_back(r);
    run_inst(9'h0A5, 1, 1, 1, -1);
    r = got_q[0];
`ifdef BIAS_ADD_RELU_EN
    check("t2_wrap", r[31:0], 32'd0);
    check("t2_neg", r[63:32], 32'd0);
`else
    check("t2_wrap", r[31:0], 32'h8000_0000);
    check("t2_neg", r[63:32], 32'hFFFF_FFFE);
`endif
    check("t2_nocarry", r[127:64], 64'd0);

    // 3: empty instruction
    run_inst(9'h033, 0, 1, 1, -1);
    // 4: toggling backpressure
    run_inst(9'h044, 4, 2, 1, -1);
    // 5: reset during row 2 of 5, then a normal run
    abort_after(9'h055, 5, 2);
    run_inst(9'h056, 5, 0, 0, -1);
    // large row_count: counter must not terminate early
    abort_after(9'h100, 16'hFFFF, 40);
    // 6: top address, ignored second start
    run_inst(9'h1FF, 6, 1, 1, 3);

    for (int t = 0; t < 6; t++) run_inst(9'($urandom_range(0, 511)), $urandom_range(1, 12), 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
